conv_psum_acc: RTL and testbench

//   Consumer of the conv PE's partial-sum output (acc bus, Tout lanes, plus valid strobe).

---
 rtl/conv_psum_acc_pkg.sv | 36 +++
 rtl/conv_psum_acc_fifo.sv | 55 +++++
 rtl/conv_psum_acc.sv | 137 +++++++++++++
 tb/tb_conv_psum_acc.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_psum_acc_pkg.sv
// Shared widths, FSM state type and the lane saturating adder for the partial-sum accumulator.
package conv_psum_acc_pkg;

    localparam int unsigned Tout      = 4;
    localparam int unsigned W_PSUM    = 32;
    localparam int unsigned W_ACC     = 32;
    localparam int unsigned W_SIZE    = 8;
    localparam int unsigned W_CHANNEL = 8;
    localparam int unsigned FIFO_D    = 4;

    // One guard bit above the wider operand is enough to detect overflow of a single add.
    localparam int unsigned W_SUM = ((W_ACC > W_PSUM) ? W_ACC : W_PSUM) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDrain
    } state_e;

    function automatic logic [W_ACC-1:0] sat_add(input logic [W_ACC-1:0]  a,
                                                 input logic [W_PSUM-1:0] b);
        logic signed [W_SUM-1:0] s;
        logic signed [W_SUM-1:0] hi;
        logic signed [W_SUM-1:0] lo;
        s  = W_SUM'(signed'(a)) + W_SUM'(signed'(b));
        hi = (W_SUM'(1) <<< (W_ACC - 1)) - W_SUM'(1);
        lo = -(W_SUM'(1) <<< (W_ACC - 1));
        if (s > hi) begin
            return W_ACC'(hi);
        end else if (s < lo) begin
            return W_ACC'(lo);
        end
        return W_ACC'(s);
    endfunction

endpackage

// File: rtl/conv_psum_acc_fifo.sv
// Synchronous FIFO holding final per-pixel sums; head is zero when empty.
module conv_psum_acc_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(Depth));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/conv_psum_acc.sv
// Accumulates PE partial sums across input-channel tiles of one output row and emits the
// final per-pixel lane sums through an output FIFO.
module conv_psum_acc
    import conv_psum_acc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_start,
    input  logic [W_SIZE-1:0]         cfg_width_m1,
    input  logic [W_CHANNEL-1:0]      cfg_tiles_m1,
    input  logic [Tout*W_PSUM-1:0]    pe_acc,
    input  logic                      pe_vld,
    output logic [Tout*W_ACC-1:0]     o_data,
    output logic                      o_vld,
    input  logic                      o_ready,
    output logic                      o_last,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err_ovf
);

    localparam int unsigned FW = Tout * W_ACC + 1;

    state_e                    state_q, state_d;
    logic [W_SIZE-1:0]         col_q, col_d;
    logic [W_SIZE-1:0]         width_q, width_d;
    logic [W_CHANNEL-1:0]      tile_q, tile_d;
    logic [W_CHANNEL-1:0]      tiles_q, tiles_d;
    logic                      ovf_q, ovf_d;
    logic [Tout*W_ACC-1:0]     row_buf_q [2**W_SIZE];
    logic [Tout*W_ACC-1:0]     prev;
    logic [Tout*W_ACC-1:0]     sum;
    logic                      beat, last_col, last_tile;
    logic                      push, pop, full, empty;
    logic [FW-1:0]             fifo_rdata;
    logic [$clog2(FIFO_D):0]   fifo_count;

    assign beat      = (state_q == StAcc) && pe_vld;
    assign last_col  = (col_q == width_q);
    assign last_tile = (tile_q == tiles_q);
    // Tile 0 starts from zero so stale buffer contents never leak into a new row.
    assign prev      = (tile_q == '0) ? '0 : row_buf_q[col_q];

    always_comb begin
        sum = '0;
        for (int a = 0; a < Tout; a++) begin
            sum[a*W_ACC +: W_ACC] = sat_add(prev[a*W_ACC +: W_ACC], pe_acc[a*W_PSUM +: W_PSUM]);
        end
    end

    assign push  = beat && last_tile;
    assign pop   = o_vld && o_ready;
    assign ovf_d = ovf_q | (push && full && !pop);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        tile_d  = tile_q;
        width_d = width_q;
        tiles_d = tiles_q;
        o_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StAcc;
                    col_d   = '0;
                    tile_d  = '0;
                    width_d = cfg_width_m1;
                    tiles_d = cfg_tiles_m1;
                end
            end
            StAcc: begin
                if (beat) begin
                    if (last_col) begin
                        col_d  = '0;
                        tile_d = tile_q + 1'b1;
                        if (last_tile) state_d = StDrain;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (empty) begin
                    state_d = StIdle;
                    o_done  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            col_q   <= '0;
            tile_q  <= '0;
            width_q <= '0;
            tiles_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            tile_q  <= tile_d;
            width_q <= width_d;
            tiles_q <= tiles_d;
            ovf_q   <= ovf_d;
        end
    end

    // Write lands at the beat's edge, so a width-1 row reads it back on the very next beat.
    always_ff @(posedge clk) begin
        if (rstn && beat && !last_tile) row_buf_q[col_q] <= sum;
    end

    conv_psum_acc_fifo #(
        .Width (FW),
        .Depth (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata ({last_col, sum}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign o_vld     = !empty;
    assign o_data    = fifo_rdata[FW-2:0];
    assign o_last    = fifo_rdata[FW-1];
    assign o_busy    = (state_q != StIdle) || (fifo_count != '0);
    assign o_err_ovf = ovf_q;

endmodule

// File: tb/tb_conv_psum_acc.sv
// Self-checking bench for conv_psum_acc: directed tables, corner sequences and random rows
// checked every cycle against a queue-based reference model.
module tb_conv_psum_acc;
    import conv_psum_acc_pkg::*;

    localparam int LW = Tout * W_ACC;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   i_start = 1'b0;
    logic [W_SIZE-1:0]      cfg_width_m1 = '0;
    logic [W_CHANNEL-1:0]   cfg_tiles_m1 = '0;
    logic [Tout*W_PSUM-1:0] pe_acc = '0;
    logic                   pe_vld = 1'b0;
    logic [LW-1:0]          o_data;
    logic                   o_vld;
    logic                   o_ready = 1'b1;
    logic                   o_last;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_err_ovf;

    always #5 clk = ~clk;

    conv_psum_acc dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_start      (i_start),
        .cfg_width_m1 (cfg_width_m1),
        .cfg_tiles_m1 (cfg_tiles_m1),
        .pe_acc       (pe_acc),
        .pe_vld       (pe_vld),
        .o_data       (o_data),
        .o_vld        (o_vld),
        .o_ready      (o_ready),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err_ovf    (o_err_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    int n_done = 0;

    // Model state: queue of expected FIFO entries {last, data} plus row bookkeeping.
    logic [LW:0]   mq[$];
    bit            m_ovf = 0, m_active = 0, m_drain = 0, mon_en = 0;
    // Per-cycle hints from the stimulus describing what the current beat means.
    bit            f_push = 0, f_last_beat = 0, f_start = 0;
    logic [LW:0]   f_push_val = '0;
    bit            rdy_rand = 0, noise = 0;
    logic [LW-1:0] pe_tab [16][256];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W_ACC-1:0] ref_sat(input logic [W_ACC-1:0] a,
                                                 input logic [W_PSUM-1:0] b);
        longint s, hi, lo;
        s  = longint'(signed'(a)) + longint'(signed'(b));
        hi = (longint'(1) <<< (W_ACC - 1)) - 1;
        lo = -(longint'(1) <<< (W_ACC - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return W_ACC'(s);
    endfunction

    function automatic logic [W_PSUM-1:0] rnd_lane();
        logic [31:0] v;
        case ($urandom_range(3))
            0: v = $urandom;
            1: v = 32'($urandom_range(200)) - 32'd100;
            2: v = 32'h7FFF_FF00 + 32'($urandom_range(255));
            default: v = 32'h8000_0000 + 32'($urandom_range(255));
        endcase
        return W_PSUM'(v);
    endfunction

    always @(negedge clk) begin : monitor
        bit pop;
        if (mon_en) begin
            check("o_vld", o_vld, mq.size() != 0);
            check("o_data", o_data, (mq.size() != 0) ? mq[0][LW-1:0] : '0);
            check("o_last", o_last, (mq.size() != 0) ? mq[0][LW] : 1'b0);
            check("o_busy", o_busy, m_active || mq.size() != 0);
            check("o_done", o_done, m_drain && mq.size() == 0);
            check("o_err_ovf", o_err_ovf, m_ovf);
            if (o_vld && o_ready) n_pop++;
            if (o_done) n_done++;
            if (!rstn) begin
                mq.delete();
                m_active = 0;
                m_drain  = 0;
                m_ovf    = 0;
            end else begin
                if (m_drain && mq.size() == 0) begin
                    m_drain  = 0;
                    m_active = 0;
                end
                pop = o_ready && mq.size() != 0;
                if (pop) void'(mq.pop_front());
                if (f_push) begin
                    if (mq.size() < FIFO_D) mq.push_back(f_push_val);
                    else m_ovf = 1;
                end
                if (f_last_beat) m_drain = 1;
                if (f_start) m_active = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_rand) o_ready = 1'($urandom_range(1));
    endtask

    task automatic do_reset();
        pe_vld = 0;
        i_start = 0;
        rstn = 0;
        step();
        step();
        rstn = 1;
        step();
    endtask

    // Drives one full row from pe_tab; expected final sums come from folding tiles per pixel.
    task automatic run_row(input int wm1, input int tm1, input int gap_pct);
        logic [LW-1:0] accv [256];
        i_start = 1;
        cfg_width_m1 = W_SIZE'(wm1);
        cfg_tiles_m1 = W_CHANNEL'(tm1);
        f_start = 1;
        pe_vld = noise ? 1'($urandom_range(1)) : 1'b0;
        step();
        i_start = 0;
        f_start = 0;
        for (int t = 0; t <= tm1; t++) begin
            for (int c = 0; c <= wm1; c++) begin
                while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    pe_vld = 0;
                    f_push = 0;
                    f_last_beat = 0;
                    i_start = noise ? 1'($urandom_range(1)) : 1'b0;
                    cfg_width_m1 = W_SIZE'($urandom);
                    cfg_tiles_m1 = W_CHANNEL'($urandom);
                    step();
                end
                i_start = 0;
                for (int a = 0; a < Tout; a++) begin
                    accv[c][a*W_ACC +: W_ACC] =
                        ref_sat((t == 0) ? '0 : accv[c][a*W_ACC +: W_ACC],
                                pe_tab[t][c][a*W_PSUM +: W_PSUM]);
                end
                pe_acc = pe_tab[t][c];
                pe_vld = 1;
                f_push = (t == tm1);
                f_push_val = {1'(c == wm1), accv[c]};
                f_last_beat = (t == tm1) && (c == wm1);
                step();
            end
        end
        pe_vld = 0;
        f_push = 0;
        f_last_beat = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 300) begin
            if (noise) begin
                pe_vld = 1'($urandom_range(1));
                pe_acc = {Tout{rnd_lane()}};
            end
            step();
            n++;
        end
        pe_vld = 0;
        if (o_busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: o_busy still 1 after %0d cycles", tag, n);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } sat_vec_t;

    sat_vec_t sat_tab [8];

    initial begin : timeout
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [LW-1:0] expv;
        int done0;

        sat_tab[0] = '{32'h7FFF_FFF0, 32'h0000_0100, 32'h7FFF_FFFF};
        sat_tab[1] = '{32'h8000_0010, 32'hFFFF_FF00, 32'h8000_0000};
        sat_tab[2] = '{32'h0000_0005, 32'hFFFF_FFF9, 32'hFFFF_FFFE};
        sat_tab[3] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF};
        sat_tab[4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        sat_tab[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        sat_tab[6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        sat_tab[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

        rstn = 0;
        repeat (3) step();
        rstn = 1;
        step();
        check("reset o_vld", o_vld, 0);
        check("reset o_data", o_data, 0);
        check("reset o_last", o_last, 0);
        check("reset o_busy", o_busy, 0);
        check("reset o_done", o_done, 0);
        check("reset o_err_ovf", o_err_ovf, 0);
        mon_en = 1;

        // Width 4, single tile: outputs equal inputs, lane k of pixel c = k + c.
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < Tout; k++) pe_tab[0][c][k*W_PSUM +: W_PSUM] = W_PSUM'(k + c);
        done0 = n_done;
        run_row(3, 0, 0);
        for (int k = 0; k < Tout; k++) expv[k*W_ACC +: W_ACC] = W_ACC'(k + 3);
        check("t1 last data", o_data, expv);
        check("t1 last flag", o_last, 1);
        wait_idle("t1 drain");
        check("t1 done count", n_done - done0, 1);

        // Width 3, three tiles of 5 each.
        for (int t = 0; t < 3; t++)
            for (int c = 0; c < 3; c++) pe_tab[t][c] = {Tout{W_PSUM'(5)}};
        run_row(2, 2, 0);
        check("t2 sum 15", o_data, {Tout{W_ACC'(15)}});
        check("t2 last flag", o_last, 1);
        wait_idle("t2 drain");

        // Saturation table: width 1, two tiles.
        foreach (sat_tab[i]) begin
            pe_tab[0][0] = {Tout{sat_tab[i].a}};
            pe_tab[1][0] = {Tout{sat_tab[i].b}};
            run_row(0, 1, 0);
            check($sformatf("sat[%0d]", i), o_data, {Tout{sat_tab[i].exp}});
            wait_idle("sat drain");
        end

        // Width 1, four tiles on consecutive cycles: each beat reads the previous write.
        for (int t = 0; t < 4; t++) pe_tab[t][0] = {Tout{W_PSUM'(t + 1)}};
        run_row(0, 3, 0);
        check("t5 sum 10", o_data, {Tout{W_ACC'(10)}});
        check("t5 last flag", o_last, 1);
        wait_idle("t5 drain");

        // Stalled downstream: 4 held, 5th beat overflows, release yields 4 pops.
        for (int c = 0; c < 8; c++) pe_tab[0][c] = {Tout{W_PSUM'(100 + c)}};
        o_ready = 0;
        run_row(7, 0, 0);
        check("t4 ovf", o_err_ovf, 1);
        check("t4 head", o_data, {Tout{W_ACC'(100)}});
        n_pop = 0;
        o_ready = 1;
        wait_idle("t4 drain");
        check("t4 pops", n_pop, 4);
        do_reset();
        check("t4 ovf cleared", o_err_ovf, 0);

        // Reset mid-accumulation, then a fresh row must ignore stale buffer contents.
        for (int t = 0; t < 3; t++)
            for (int c = 0; c < 4; c++) pe_tab[t][c] = {Tout{W_PSUM'(1000 + t)}};
        i_start = 1;
        cfg_width_m1 = 3;
        cfg_tiles_m1 = 2;
        f_start = 1;
        step();
        i_start = 0;
        f_start = 0;
        for (int b = 0; b < 6; b++) begin
            pe_acc = pe_tab[b / 4][b % 4];
            pe_vld = 1;
            step();
        end
        pe_vld = 0;
        rstn = 0;
        step();
        check("t6 rst o_vld", o_vld, 0);
        check("t6 rst o_busy", o_busy, 0);
        rstn = 1;
        step();
        for (int t = 0; t < 2; t++)
            for (int c = 0; c < 4; c++) pe_tab[t][c] = {Tout{W_PSUM'(7 + t + c)}};
        run_row(3, 1, 0);
        check("t6 restart sum", o_data, {Tout{W_ACC'(21)}});
        wait_idle("t6 drain");

        // Random rows with gaps, random backpressure, ignored starts and idle/drain beats.
        noise = 1;
        rdy_rand = 1;
        for (int r = 0; r < 40; r++) begin
            int wm1, tm1;
            wm1 = $urandom_range(7);
            tm1 = $urandom_range(3);
            for (int t = 0; t <= tm1; t++)
                for (int c = 0; c <= wm1; c++)
                    for (int a = 0; a < Tout; a++)
                        pe_tab[t][c][a*W_PSUM +: W_PSUM] = rnd_lane();
            run_row(wm1, tm1, 30);
            wait_idle("rand drain");
        end
        noise = 0;
        rdy_rand = 0;
        o_ready = 1;
        pe_vld = 0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
